// File: rtl/cos_seq_pkg.sv
// Shared types and default widths for the cosine-accelerator job sequencer.
package cos_seq_pkg;

    localparam int DEF_XW = 16;
    localparam int DEF_YW = 8;
    localparam int DEF_RW = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_e;

endpackage

// File: rtl/cos_job_fifo.sv
// Synchronous job FIFO; a pushed entry becomes visible at dout on the following cycle.
module cos_job_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push_s;
    logic          do_pop_s;

    // Pointer and occupancy update; full refuses a push even when a pop happens too.
    always_comb begin
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == (AW+1)'(0));

endmodule

// File: rtl/cos_job_sequencer.sv
// Feeds buffered (x, y) jobs to the cosine accelerator one at a time, with a
// timeout watchdog and a tagged valid/ready result register.
module cos_job_sequencer
    import cos_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int XW      = DEF_XW,
    parameter int YW      = DEF_YW,
    parameter int RW      = DEF_RW,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XW-1:0]    in_x,
    input  logic [YW-1:0]    in_y,
    output logic             acc_start,
    output logic [XW-1:0]    acc_x,
    output logic [YW-1:0]    acc_y,
    input  logic             acc_done,
    input  logic [RW-1:0]    acc_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RW-1:0]    res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err,
    output logic             busy,
    output logic             err_sticky
);

    localparam int          FW        = XW + YW;
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    state_e            state_q, state_d;
    logic [15:0]       wd_q, wd_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              acc_start_q, acc_start_d;
    logic [XW-1:0]     acc_x_q, acc_x_d;
    logic [YW-1:0]     acc_y_q, acc_y_d;
    logic              res_valid_q, res_valid_d;
    logic [RW-1:0]     res_data_q, res_data_d;
    logic [TAG_W-1:0]  res_tag_q, res_tag_d;
    logic              res_err_q, res_err_d;
    logic              err_sticky_q, err_sticky_d;

    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [FW-1:0]     fifo_dout_s;

    assign fifo_push_s = in_valid && !fifo_full_s;

    cos_job_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .din   ({in_x, in_y}),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Next-state logic for the launch/wait sequencer and the result register.
    always_comb begin
        state_d      = state_q;
        wd_d         = wd_q;
        tag_d        = tag_q;
        acc_start_d  = 1'b0;
        acc_x_d      = acc_x_q;
        acc_y_d      = acc_y_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_tag_d    = res_tag_q;
        res_err_d    = res_err_q;
        err_sticky_d = err_sticky_q;
        fifo_pop_s   = 1'b0;

        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end

        case (state_q)
            IDLE: begin
                // An unconsumed result blocks the next launch so it is never overwritten.
                if (!fifo_empty_s && !res_valid_q) begin
                    fifo_pop_s  = 1'b1;
                    acc_x_d     = fifo_dout_s[FW-1:YW];
                    acc_y_d     = fifo_dout_s[YW-1:0];
                    acc_start_d = 1'b1;
                    state_d     = LAUNCH;
                end else begin
                    state_d = IDLE;
                end
            end
            LAUNCH: begin
                wd_d    = 16'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (acc_done) begin
                    res_data_d  = acc_result;
                    res_tag_d   = tag_q;
                    res_err_d   = 1'b0;
                    res_valid_d = 1'b1;
                    tag_d       = tag_q + TAG_W'(1);
                    state_d     = IDLE;
                end else if (wd_q == TIMEOUT_C) begin
                    res_data_d   = '0;
                    res_tag_d    = tag_q;
                    res_err_d    = 1'b1;
                    res_valid_d  = 1'b1;
                    err_sticky_d = 1'b1;
                    tag_d        = tag_q + TAG_W'(1);
                    state_d      = IDLE;
                end else begin
                    wd_d    = wd_q + 16'd1;
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset also silently drops any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wd_q         <= 16'd0;
            tag_q        <= '0;
            acc_start_q  <= 1'b0;
            acc_x_q      <= '0;
            acc_y_q      <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_tag_q    <= '0;
            res_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wd_q         <= wd_d;
            tag_q        <= tag_d;
            acc_start_q  <= acc_start_d;
            acc_x_q      <= acc_x_d;
            acc_y_q      <= acc_y_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_tag_q    <= res_tag_d;
            res_err_q    <= res_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign in_ready   = !fifo_full_s;
    assign acc_start  = acc_start_q;
    assign acc_x      = acc_x_q;
    assign acc_y      = acc_y_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_tag    = res_tag_q;
    assign res_err    = res_err_q;
    assign err_sticky = err_sticky_q;
    assign busy       = (state_q != IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_cos_job_sequencer.sv
// Self-checking bench: cycle-accurate job-level reference model plus directed
// scenarios with hand-computed expectations, then a randomized soak.
module tb_cos_job_sequencer;

    localparam int DEPTH   = 4;
    localparam int XW      = 16;
    localparam int YW      = 8;
    localparam int RW      = 16;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 20;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [XW-1:0]    in_x = '0;
    logic [YW-1:0]    in_y = '0;
    logic             acc_start;
    logic [XW-1:0]    acc_x;
    logic [YW-1:0]    acc_y;
    logic             acc_done = 1'b0;
    logic [RW-1:0]    acc_result = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [RW-1:0]    res_data;
    logic [TAG_W-1:0] res_tag;
    logic             res_err;
    logic             busy;
    logic             err_sticky;

    always #5 clk = ~clk;

    cos_job_sequencer #(
        .DEPTH(DEPTH), .XW(XW), .YW(YW), .RW(RW), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .acc_start(acc_start), .acc_x(acc_x), .acc_y(acc_y),
        .acc_done(acc_done), .acc_result(acc_result), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag), .res_err(res_err),
        .busy(busy), .err_sticky(err_sticky)
    );

    typedef struct { logic [XW-1:0] x; logic [YW-1:0] y; } job_t;
    typedef struct { logic [RW-1:0] data; int tag; bit err; } res_t;

    int errors = 0;
    int checks = 0;
    int fail_prints = 0;
    int cyc = 0;

    // reference model: jobs waiting, the job in flight (by launch cycle), result slot
    job_t          m_q[$];
    bit            m_ok = 0;
    bit            m_active = 0;
    int            m_start = 0;
    logic [XW-1:0] m_ax = '0;
    logic [YW-1:0] m_ay = '0;
    bit            m_rv = 0;
    logic [RW-1:0] m_rd = '0;
    int            m_rtag = 0;
    bit            m_rerr = 0;
    int            m_tag = 0;
    bit            m_sticky = 0;

    // accelerator stand-in and observation log
    bit            acc_pend = 0;
    int            acc_due = 0;
    int            lat_mode = 3;
    bit            rand_lat = 0;
    bit            fixed_res = 0;
    int            spur_pct = 0;
    int            start_count = 0;
    int            last_start = -1;
    int            rise_cyc = -1;
    logic [RW-1:0] rise_data = '0;
    int            rise_tag = -1;
    bit            rise_err = 0;
    bit            prev_rv = 0;
    bit            in_ready_seen = 0;
    int            last_push_cyc = -1;
    res_t          log_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
            end
        end
    endtask

    task automatic compare();
        chk("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
        chk("acc_start", 32'(acc_start), 32'(m_active && cyc == m_start));
        chk("acc_x", 32'(acc_x), 32'(m_ax));
        chk("acc_y", 32'(acc_y), 32'(m_ay));
        chk("res_valid", 32'(res_valid), 32'(m_rv));
        if (m_rv) begin
            chk("res_data", 32'(res_data), 32'(m_rd));
            chk("res_tag", 32'(res_tag), 32'(m_rtag));
            chk("res_err", 32'(res_err), 32'(m_rerr));
        end
        chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
        chk("busy", 32'(busy), 32'(m_active || m_q.size() != 0));
    endtask

    function automatic int pick_lat();
        int r;
        if (!rand_lat) return lat_mode;
        r = int'($urandom_range(0, 99));
        if (r < 5) return -1;
        if (r < 10) return 1 + TIMEOUT;
        return int'($urandom_range(1, 8));
    endfunction

    task automatic observe();
        int lat;
        if (acc_start === 1'b1) begin
            start_count++;
            last_start = cyc;
            lat = pick_lat();
            acc_pend = (lat > 0);
            acc_due = cyc + lat;
        end
        if (res_valid === 1'b1 && !prev_rv) begin
            rise_cyc = cyc;
            rise_data = res_data;
            rise_tag = int'(res_tag);
            rise_err = res_err;
        end
        prev_rv = (res_valid === 1'b1);
        if (res_valid === 1'b1 && res_ready === 1'b1) begin
            log_q.push_back('{res_data, int'(res_tag), res_err});
        end
        in_ready_seen = (in_ready === 1'b1);
    endtask

    // Advance the reference by one clock using the inputs held during this cycle.
    task automatic model_step();
        bit   can_push;
        bit   pop_now;
        job_t j;
        if (rst) begin
            m_q.delete();
            m_active = 0; m_ax = '0; m_ay = '0;
            m_rv = 0; m_rd = '0; m_rtag = 0; m_rerr = 0;
            m_tag = 0; m_sticky = 0; m_ok = 1;
            return;
        end
        can_push = m_q.size() < DEPTH;
        pop_now = !m_active && !m_rv && m_q.size() > 0;
        if (m_rv && res_ready) m_rv = 0;
        if (m_active && cyc > m_start) begin
            if (acc_done) begin
                m_rv = 1; m_rd = acc_result; m_rerr = 0; m_rtag = m_tag;
                m_tag = (m_tag + 1) % (1 << TAG_W); m_active = 0;
            end else if (cyc == m_start + 1 + TIMEOUT) begin
                m_rv = 1; m_rd = '0; m_rerr = 1; m_rtag = m_tag; m_sticky = 1;
                m_tag = (m_tag + 1) % (1 << TAG_W); m_active = 0;
            end
        end
        if (pop_now) begin
            j = m_q.pop_front();
            m_ax = j.x; m_ay = j.y;
            m_active = 1; m_start = cyc + 1;
        end
        if (in_valid && can_push) m_q.push_back('{in_x, in_y});
    endtask

    task automatic tick();
        bit was_rst;
        @(negedge clk);
        if (m_ok) compare();
        observe();
        @(posedge clk);
        was_rst = rst;
        model_step();
        cyc++;
        if (was_rst) acc_pend = 0;
        #1;
        acc_done = 1'b0;
        if (acc_pend && acc_due == cyc) begin
            acc_done = 1'b1;
            acc_pend = 0;
        end else if (spur_pct > 0 && int'($urandom_range(0, 99)) < spur_pct) begin
            acc_done = 1'b1;
        end
        acc_result = fixed_res ? 16'h7FF0 : RW'($urandom);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_job(input logic [XW-1:0] x, input logic [YW-1:0] y);
        int c0;
        in_valid = 1'b1; in_x = x; in_y = y;
        for (int i = 0; i < 20; i++) begin
            c0 = cyc;
            tick();
            if (in_ready_seen) begin
                last_push_cyc = c0;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        log_q.delete();
        start_count = 0; rise_cyc = -1; last_start = -1;
    endtask

    initial begin
        int accepted;
        int idx;
        int sc;
        int t;
        logic [RW-1:0] rd;
        int rt;

        // single job, fixed accelerator latency of 5
        reset_dut();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        res_ready = 1'b1; lat_mode = 5; fixed_res = 1;
        push_job(16'h1000, 8'h05);
        t = last_push_cyc;
        run(20);
        chk("t1_start_cyc", 32'(last_start), 32'(t + 2));
        chk("t1_starts", 32'(start_count), 32'd1);
        chk("t1_rise_cyc", 32'(rise_cyc), 32'(t + 8));
        chk("t1_data", 32'(rise_data), 32'h7FF0);
        chk("t1_tag", 32'(rise_tag), 32'd0);
        chk("t1_err", 32'(rise_err), 32'd0);
        fixed_res = 0;

        // backpressure: one in flight plus DEPTH buffered
        reset_dut();
        res_ready = 1'b0; lat_mode = 3;
        accepted = 0; idx = 0; in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in_x = 16'h0100 + 16'(idx); in_y = 8'(idx);
            tick();
            if (in_ready_seen) begin accepted++; idx++; end
        end
        chk("t2_accepted", 32'(accepted), 32'd5);
        chk("t2_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0; res_ready = 1'b1;
        run(60);
        chk("t2_nres", 32'(log_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < log_q.size(); i++) begin
            chk("t2_tag", 32'(log_q[i].tag), 32'(i));
            chk("t2_err", 32'(log_q[i].err), 32'd0);
        end

        // output stall blocks relaunch and keeps result stable
        reset_dut();
        res_ready = 1'b0; lat_mode = 2;
        push_job(16'h2222, 8'h11);
        push_job(16'h3333, 8'h22);
        run(10);
        rd = rise_data; rt = rise_tag; sc = start_count;
        run(10);
        chk("t3_starts", 32'(start_count), 32'd1);
        chk("t3_hold_v", 32'(res_valid), 32'd1);
        chk("t3_hold_d", 32'(res_data), 32'(rd));
        chk("t3_hold_t", 32'(res_tag), 32'(rt));
        res_ready = 1'b1;
        run(15);
        chk("t3_starts2", 32'(start_count), 32'(sc + 1));
        chk("t3_nres", 32'(log_q.size()), 32'd2);

        // timeout, then a normal job with the sticky flag still set
        reset_dut();
        res_ready = 1'b1; lat_mode = -1;
        push_job(16'h4444, 8'h33);
        run(30);
        chk("t4_rise_cyc", 32'(rise_cyc), 32'(last_start + 22));
        chk("t4_data", 32'(rise_data), 32'd0);
        chk("t4_err", 32'(rise_err), 32'd1);
        chk("t4_sticky", 32'(err_sticky), 32'd1);
        lat_mode = 3;
        push_job(16'h5555, 8'h44);
        run(15);
        chk("t4_nres", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            chk("t4_err2", 32'(log_q[1].err), 32'd0);
            chk("t4_tag2", 32'(log_q[1].tag), 32'd1);
        end
        chk("t4_sticky2", 32'(err_sticky), 32'd1);

        // done exactly in the timeout cycle wins; one cycle later it is ignored
        reset_dut();
        res_ready = 1'b1; lat_mode = 1 + TIMEOUT;
        push_job(16'h6666, 8'h55);
        run(30);
        chk("t5_bnd_err", 32'(rise_err), 32'd0);
        chk("t5_bnd_rise", 32'(rise_cyc), 32'(last_start + 22));
        lat_mode = 2 + TIMEOUT;
        push_job(16'h7777, 8'h66);
        run(30);
        chk("t5_late_err", 32'(rise_err), 32'd1);
        chk("t5_nres", 32'(log_q.size()), 32'd2);
        // spurious done in the LAUNCH cycle, then in IDLE
        lat_mode = 4;
        in_valid = 1'b1; in_x = 16'h8888; in_y = 8'h77;
        tick();
        in_valid = 1'b0;
        tick();
        acc_done = 1'b1;
        tick();
        run(15);
        acc_done = 1'b1;
        tick();
        run(5);
        chk("t5_nres2", 32'(log_q.size()), 32'd3);
        if (log_q.size() == 3) chk("t5_err3", 32'(log_q[2].err), 32'd0);

        // reset while waiting with three jobs queued
        reset_dut();
        res_ready = 1'b1; lat_mode = -1;
        for (int i = 0; i < 4; i++) push_job(16'h9000 + 16'(i), 8'(i));
        run(5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_res_valid", 32'(res_valid), 32'd0);
        chk("t6_acc_x", 32'(acc_x), 32'd0);
        chk("t6_sticky", 32'(err_sticky), 32'd0);
        run(30);
        chk("t6_nres", 32'(log_q.size()), 32'd0);
        lat_mode = 3;
        push_job(16'hABCD, 8'hEF);
        run(15);
        chk("t6_nres2", 32'(log_q.size()), 32'd1);
        if (log_q.size() == 1) chk("t6_tag", 32'(log_q[0].tag), 32'd0);

        // randomized soak against the model
        reset_dut();
        rand_lat = 1; spur_pct = 3;
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 99) < 50);
            in_x = XW'($urandom);
            in_y = YW'($urandom);
            res_ready = ($urandom_range(0, 99) < 70);
            rst = ($urandom_range(0, 999) < 3);
            tick();
        end
        rst = 1'b0; spur_pct = 0; in_valid = 1'b0; res_ready = 1'b1;
        run(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cos_job_sequencer.md
Name: cos_job_sequencer

Overview:
Upstream job-feeding stage for the cosine accelerator.
- Buffers (x, y) job requests from a valid/ready producer in a small FIFO.
- Launches one job at a time into the accelerator with a start pulse and holds its operands stable until done.
- Captures the 16-bit cosine result into a tagged valid/ready output register.
- Bounds each job with a timeout watchdog.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
XW, 16, x operand width (matches accelerator xin)
YW, 8, y operand width (matches accelerator yin)
RW, 16, result width (matches accelerator cosx)
TAG_W, 4, job tag width; wraps modulo 2^TAG_W
TIMEOUT, 1023, max WAIT cycles before job is aborted; must be < 2^16

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  job offered
in_ready  out  1  FIFO can accept; equals !full
in_x  in  XW  job x operand
in_y  in  YW  job y operand
acc_start  out  1  one-cycle launch pulse to accelerator
acc_x  out  XW  operand x, stable from start until done/abort
acc_y  out  YW  operand y, stable from start until done/abort
acc_done  in  1  one-cycle completion pulse from accelerator
acc_result  in  RW  cosine result, valid when acc_done=1
res_valid  out  1  output register holds a result
res_ready  in  1  consumer accepts result
res_data  out  RW  result (0 on timeout)
res_tag  out  TAG_W  tag of job producing res_data
res_err  out  1  result came from a timeout abort
busy  out  1  state != IDLE or FIFO non-empty
err_sticky  out  1  set on any timeout; cleared only by rst

Behaviour:
- Reset (sync, rst=1 at posedge): FIFO emptied; state=IDLE; tag counter=0; watchdog=0.
  - Output values: acc_start=0, acc_x=0, acc_y=0, res_valid=0, res_data=0, res_tag=0, res_err=0, err_sticky=0, busy=0.
  - in_ready=1 once rst deasserts.
  - Reset mid-job aborts that job silently: no result, no error.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready=0 when full, including a cycle in which a pop also occurs (no same-cycle push-through when full).
  - Pointers wrap modulo DEPTH.
  - A pushed entry is visible to the FSM the cycle after the push.
- FSM states:
  - IDLE: if FIFO non-empty && !res_valid → pop head into acc_x/acc_y, go LAUNCH.
  - LAUNCH: acc_start=1 for exactly this one cycle; clear watchdog; go WAIT.
  - WAIT: acc_x/acc_y held.
    - On acc_done: res_data<=acc_result, res_tag<=tag, res_err<=0, res_valid<=1, tag<=tag+1, go IDLE.
    - Else, if watchdog==TIMEOUT: res_data<=0, res_err<=1, res_valid<=1, err_sticky<=1, tag<=tag+1, go IDLE.
    - Else watchdog++.
    - acc_done wins if it arrives in the timeout cycle.
- acc_done outside WAIT (including in the LAUNCH cycle) is ignored.
- Output handshake:
  - res_valid clears on res_valid && res_ready.
  - A new launch requires res_valid==0 in IDLE, so a result is never overwritten.
  - res_data/res_tag/res_err are stable while res_valid && !res_ready.
- Latency:
  - Push at cycle t into an empty FIFO with an idle FSM → acc_start high at t+2.
  - acc_done at cycle d → res_valid high at d+1.
  - With res_ready held high, back-to-back jobs re-launch at d+3 (output register clears at d+2; IDLE pops at d+2; LAUNCH at d+3).
- Tag counter wraps 2^TAG_W-1 → 0.
- acc_x/acc_y retain the last operands after done or abort until the next pop.

Decomposition:
- Package cos_seq_pkg:
  - FSM state enum {IDLE, LAUNCH, WAIT}
  - default width localparams (XW/YW/RW = 16/8/16)
- Sub-module cos_job_fifo: synchronous FIFO, DEPTH × (XW+YW); ports push, pop, din, dout, full, empty.
- FSM, watchdog, tag counter and output register live in the top of this block.

Test Plan:
- Single job: push x=16'h1000, y=8'h05; accelerator model returns 16'h7FF0 five cycles after start → acc_start exactly once at t+2, acc_x/acc_y stable until done, res_valid at done+1, res_data=16'h7FF0, res_tag=0, res_err=0.
- FIFO full/backpressure: hold res_ready=0, push 6 jobs with DEPTH=4 → one job in flight, then 4 buffered, then in_ready=0 and no 6th push. Release res_ready → all 5 results delivered in order with tags 0..4.
- Output stall: res_ready=0 for 10 cycles after first result → no second acc_start; res_data/res_tag unchanged until handshake completes.
- Timeout: TIMEOUT=20, accelerator never pulses done → res_valid at start+22 with res_data=0, res_err=1, err_sticky=1. Next job completes normally with res_err=0 and err_sticky still 1.
- Done at timeout boundary and spurious done: acc_done in the watchdog==TIMEOUT cycle → normal result, res_err=0. acc_done pulsed in IDLE/LAUNCH → ignored, no result.
- Reset mid-WAIT with 3 jobs queued: rst for 1 cycle → all outputs at reset values, FIFO empty, no result emitted. A fresh job afterwards gets res_tag=0.
